// File: rtl/echo_delay_mixer_if.sv
// Sample stream bus for echo_delay_mixer: ADC sample in, echo controls, processed sample and status out.
interface echo_delay_mixer_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 10
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic              echo_on;
  logic [ADDR_W-1:0] delay;
  logic [DATA_W-1:0] sample_out;
  logic              out_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output sample_valid, sample_in, echo_on, delay,
    input  sample_out, out_valid, busy, overrun
  );

  modport slave (
    input  sample_valid, sample_in, echo_on, delay,
    output sample_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/echo_delay_mixer.sv
// Single-tap echo mixer over a circular sample buffer; IDLE->READ->MIX->WRITE per accepted sample.
// Define ECHO_FEEDBACK_EN to write the attenuated mix back into the buffer (regenerating echoes).
module echo_delay_mixer #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 10
) (
  input logic               clk,
  input logic               reset,
  echo_delay_mixer_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned SW    = DATA_W + 1;
  localparam int          MID   = 1 << (DATA_W - 1);
  localparam logic signed [SW-1:0] POS_MAX = SW'(MID - 1);
  localparam logic signed [SW-1:0] NEG_MIN = SW'(-MID);

  typedef enum logic [1:0] {IDLE, READ, MIX, WRITE} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] smp_q;
  logic [DATA_W-1:0] wval_q;
  logic              echo_q;
  logic              tap_q;
  logic [ADDR_W-1:0] dly_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill;
  logic signed [DATA_W-1:0] y_q;

  logic                 accept_c;
  logic                 write_c;
  logic [ADDR_W-1:0]    rd_addr_c;
  logic signed [SW-1:0] dry_c;
  logic signed [SW-1:0] wet_c;
  logic signed [SW-1:0] mix_c;
`ifdef ECHO_FEEDBACK_EN
  logic signed [SW-1:0] fb_c;
`endif

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > POS_MAX)      sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < NEG_MIN) sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                  sat = v[DATA_W-1:0];
  endfunction

  // Signed -> offset binary is an MSB flip.
  function automatic logic [DATA_W-1:0] to_code(input logic signed [DATA_W-1:0] v);
    to_code = {~v[DATA_W-1], v[DATA_W-2:0]};
  endfunction

  assign accept_c  = (state_q == IDLE) && bus.sample_valid;
  assign write_c   = reset && (state_q == WRITE);
  assign rd_addr_c = wr_ptr - dly_q;

  // An invalid tap or disabled echo contributes midscale, i.e. zero signal.
  assign dry_c = $signed({1'b0, smp_q}) - SW'(MID);
  assign wet_c = (echo_q && tap_q) ? ($signed({1'b0, mem_q}) - SW'(MID)) : '0;
  assign mix_c = dry_c + (wet_c >>> 1);
`ifdef ECHO_FEEDBACK_EN
  assign fb_c  = dry_c + (wet_c >>> 2);
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.sample_valid) state_d = READ;
      READ:    state_d = MIX;
      MIX:     state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; busy tracks the state being registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      bus.busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus.busy <= (state_d != IDLE);
    end
  end

  // Per-sample capture and pipeline registers; contents are don't-care outside their states.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      smp_q  <= bus.sample_in;
      echo_q <= bus.echo_on;
      dly_q  <= bus.delay;
    end
    if (state_q == READ) begin
      tap_q <= (dly_q != '0) && (fill >= dly_q);
    end
    if (state_q == MIX) begin
      y_q <= sat(mix_c);
`ifdef ECHO_FEEDBACK_EN
      wval_q <= (echo_q && tap_q) ? to_code(sat(fb_c)) : smp_q;
`else
      wval_q <= smp_q;
`endif
    end
  end

  // Delay buffer: registered read, no reset so history survives (masked by fill).
  always_ff @(posedge clk) begin
    if (state_q == READ) mem_q <= mem[rd_addr_c];
    if (write_c)         mem[wr_ptr] <= wval_q;
  end

  // Pointers, fill count and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr         <= '0;
      fill           <= '0;
      bus.sample_out <= DATA_W'(MID);
      bus.out_valid  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if ((state_q != IDLE) && bus.sample_valid) bus.overrun <= 1'b1;
      if (state_q == WRITE) begin
        wr_ptr         <= wr_ptr + ADDR_W'(1);
        if (fill != '1) fill <= fill + ADDR_W'(1);
        bus.sample_out <= to_code(y_q);
        bus.out_valid  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_echo_delay_mixer.sv
// Scoreboard bench for echo_delay_mixer: reference model keeps the sample history as a queue.
module tb_echo_delay_mixer;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned ADDR_W = 10;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  echo_delay_mixer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  echo_delay_mixer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   cyc = 0;
  exp_t expq[$];
  int   hist[$];
  int   next_ok  = 0;
  bit   ovr      = 1'b0;
  bit   in_rst   = 1'b1;
  int   nvec     = 0;
  int   nerr     = 0;
  int   last_out = -1;
  int   nout     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Model: an accepted sample sees the history of previously written values.
  task automatic send(input int s, input bit e, input int d);
    int  fill, dry, wet;
    bit  tap;
    bus.sample_valid = 1'b1;
    bus.sample_in    = DATA_W'(s);
    bus.echo_on      = e;
    bus.delay        = ADDR_W'(d);
    tick();
    bus.sample_valid = 1'b0;
    bus.sample_in    = DATA_W'($urandom);
    bus.echo_on      = 1'($urandom);
    bus.delay        = ADDR_W'($urandom);
    if (cyc >= next_ok) begin
      fill = (hist.size() > 1023) ? 1023 : hist.size();
      tap  = e && (d != 0) && (fill >= d);
      dry  = s - 2048;
      wet  = tap ? hist[hist.size() - d] - 2048 : 0;
      expq.push_back('{clamp(dry + (wet >>> 1)) + 2048, cyc + 3});
`ifdef ECHO_FEEDBACK_EN
      hist.push_back(tap ? clamp(dry + (wet >>> 2)) + 2048 : s);
`else
      hist.push_back(s);
`endif
      if (hist.size() > 1024) void'(hist.pop_front());
      next_ok = cyc + 4;
    end else begin
      ovr = 1'b1;
    end
  endtask

  task automatic send_wait(input int s, input bit e, input int d);
    send(s, e, d);
    idle(4);
  endtask

  task automatic do_reset();
    in_rst  = 1'b1;
    reset   = 1'b0;
    expq.delete();
    hist.delete();
    next_ok = 0;
    ovr     = 1'b0;
    idle(2);
    reset = 1'b1;
    check("reset_sample_out", bus.sample_out, 'h800);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_overrun", bus.overrun, 0);
    in_rst = 1'b0;
  endtask

  // Monitor: compare every output strobe against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!in_rst) begin
      check("busy", bus.busy, int'(cyc < next_ok - 1));
      if (bus.out_valid) begin
        last_out = bus.sample_out;
        nout++;
        if (expq.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = expq.pop_front();
          check("sample_out", bus.sample_out, e.val);
          check("latency", cyc, e.due);
        end
      end else if (expq.size() != 0 && cyc > expq[0].due) begin
        check("missing_out_valid", cyc, expq[0].due);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int g, s, d;
    bit e;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.echo_on      = 1'b0;
    bus.delay        = '0;
    do_reset();

    // Bypass
    send_wait('h9A0, 1'b0, 0);
    check("bypass", last_out, 'h9A0);

    // Single echo with delay 4
    do_reset();
    send_wait('hC00, 1'b1, 4);
    check("echo_out1", last_out, 'hC00);
    for (int i = 2; i <= 4; i++) begin
      send_wait('h800, 1'b1, 4);
      check("echo_out_pre", last_out, 'h800);
    end
    send_wait('h800, 1'b1, 4);
    check("echo_out5", last_out, 'hA00);

    // Saturation
    do_reset();
    send_wait('hF00, 1'b1, 1);
    send_wait('hF00, 1'b1, 1);
    check("saturate", last_out, 'hFFF);

    // Fill guard and zero delay
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_wait('hE00, 1'b1, 10);
      check("fill_guard", last_out, 'hE00);
    end
    send_wait('h345, 1'b1, 0);
    check("delay_zero", last_out, 'h345);

    // Overrun: back-to-back strobes, second dropped
    do_reset();
    n0 = nout;
    send('h900, 1'b0, 0);
    send('h700, 1'b0, 0);
    idle(5);
    check("overrun_outputs", nout - n0, 1);
    check("overrun_flag", bus.overrun, 1);
    send_wait('h800, 1'b1, 1);
    check("overrun_wrptr", last_out, 'h880);

    // Reset mid-flight aborts the sample and its buffer write
    do_reset();
    n0 = nout;
    send('hABC, 1'b0, 0);
    do_reset();
    idle(5);
    check("abort_no_output", nout - n0, 0);
    send_wait('h800, 1'b1, 1);
    check("abort_no_write", last_out, 'h800);

    // Randomized traffic, long enough to wrap the buffer and saturate fill
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      s = int'($urandom_range(0, 4095));
      e = 1'($urandom);
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 12));
      g = int'($urandom_range(0, 6));
      send(s, e, d);
      idle(g);
    end
    idle(8);
    check("drain", expq.size(), 0);
    check("overrun_final", bus.overrun, int'(ovr));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/echo_delay_mixer.md
ECHO_DELAY_MIXER -- requirements
Module: echo_delay_mixer

Interface
REQ-001 SHALL have parameter DATA_W, default 12, sample width (unsigned offset-binary ADC code, midscale 2^(DATA_W-1)).
REQ-002 SHALL have parameter ADDR_W, default 10, delay-buffer address width (DEPTH = 2^ADDR_W = 1024 samples).
REQ-003 SHALL have port clk  input  1  system clock (fpga_sck domain, 3 MHz).
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe, sample_in holds a new ADC sample.
REQ-006 SHALL have port sample_in  input  DATA_W  ADC code from the ADC SPI capture stage.
REQ-007 SHALL have port echo_on  input  1  enables wet (echo) mix; sampled at acceptance.
REQ-008 SHALL have port delay  input  ADDR_W  echo tap offset in samples; sampled at acceptance.
REQ-009 SHALL have port sample_out  output  DATA_W  processed sample, offset-binary.
REQ-010 SHALL have port out_valid  output  1  one-cycle strobe, sample_out updated.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port overrun  output  1  sticky flag, a sample was dropped.

Function
REQ-013 SHALL contain a DEPTH x DATA_W circular buffer, write pointer wr_ptr, and a fill counter saturating at DEPTH-1.
REQ-014 SHALL implement FSM IDLE->READ->MIX->WRITE->IDLE; IDLE leaves only when sample_valid=1; all other transitions are unconditional.
REQ-015 On acceptance, SHALL latch sample_in, echo_on and delay; later changes to these inputs SHALL NOT affect the sample in flight.
REQ-016 READ SHALL issue a registered buffer read at rd_addr = (wr_ptr - delay) mod DEPTH; the data is used in MIX.
REQ-017 Tap SHALL be valid only if delay != 0 and fill >= delay; otherwise wet SHALL be treated as midscale (zero signal).
REQ-018 MIX SHALL convert to signed (code - 2048), compute y = dry + (wet >>> 1) when echo_on=1 and the tap is valid, else y = dry, and saturate y to [-2048, 2047].
REQ-019 WRITE SHALL store the buffer write value at wr_ptr, increment wr_ptr mod DEPTH (1023->0), and increment fill, saturating.
REQ-020 On the WRITE->IDLE edge, SHALL register sample_out = y + 2048 and pulse out_valid for exactly one cycle. Latency is 4 clock edges from the acceptance edge.
REQ-021 A sample_valid while busy=1 SHALL be ignored (no write, no output) and SHALL set overrun=1 until reset.
REQ-022 A sample_valid in the same cycle that out_valid is high (state IDLE) SHALL be accepted normally.
REQ-023 Buffer contents SHALL NOT be cleared by reset; stale data SHALL be masked by the fill counter only.

Reset
REQ-024 While reset=0 at a clk edge, SHALL set: state=IDLE, wr_ptr=0, fill=0, sample_out=0x800, out_valid=0, overrun=0.
REQ-025 Reset asserted mid-operation SHALL abort the sample in flight, with no buffer write and no out_valid.

Configuration
REQ-026 Macro ECHO_FEEDBACK_EN defined: buffer write value SHALL be sat(dry + (wet >>> 2)) + 2048 when echo_on=1 and the tap is valid, else sample_in (regenerating echoes).
REQ-027 Macro ECHO_FEEDBACK_EN undefined: buffer write value SHALL always be the latched sample_in (single echo); the interface is identical in both builds.

Verification
REQ-028 Reset: hold reset=0 for 2 cycles -> sample_out=0x800, out_valid=0, busy=0, overrun=0.
REQ-029 Bypass: echo_on=0, sample_in=0x9A0 strobe -> out_valid exactly 4 edges later, sample_out=0x9A0.
REQ-030 Echo (feedback off): delay=4, echo_on=1, samples 0xC00, then 0x800 x4 -> fifth output=0xA00 and outputs 2-4 = 0x800.
REQ-031 Saturation: delay=1, two samples 0xF00 -> second output=0xFFF (1792+896 clamped to 2047).
REQ-032 Fill guard: after reset, delay=10, echo_on=1, three samples 0xE00 -> all outputs=0xE00. Also delay=0 -> output=input.
REQ-033 Overrun: sample_valid on two consecutive cycles -> one out_valid only, overrun=1, wr_ptr advanced by 1.
